hashgen_ctr_dp: RTL and testbench

HASHGEN_CTR_DP -- requirements
Module: hashgen_ctr_dp

---
 rtl/hashgen_pkg.sv | 19 +
 rtl/hashgen_ctr_ch.sv | 72 +++++++
 rtl/hashgen_ctr_dp.sv | 60 ++++++
 tb/tb_hashgen_ctr_dp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hashgen_pkg.sv
// Shared definitions for the chained multi-channel counter datapath:
// per-channel command encodings and the supported parameter ranges.
package hashgen_pkg;

   // Per-channel command, two bits per channel on the op bus.
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_INC  = 2'b01,
      OP_CLR  = 2'b10,
      OP_LD   = 2'b11
   } op_e;

   // Supported parameter ranges.
   localparam int NCH_MIN   = 1;
   localparam int NCH_MAX   = 8;
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

endpackage : hashgen_pkg

// File: rtl/hashgen_ctr_ch.sv
// One counter channel: count register, wrap pulse register, next-state mux
// and the combinational wrap event that feeds the next channel's gate.
module hashgen_ctr_ch
   import hashgen_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       op,
   input  logic             gate_en,   // upstream permission to increment
   input  logic [WIDTH-1:0] ld_val,
   input  logic [WIDTH-1:0] lim,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             wrap,
   output logic             wev
);

   op_e              op_s;
   logic             inc;
   logic             at_lim;
   logic [WIDTH-1:0] cnt_d, cnt_q;
   logic             wrap_d, wrap_q;

   assign op_s   = op_e'(op);
   // ">=" rather than "==" so a value loaded above the limit still wraps.
   assign at_lim = (cnt_q >= lim);
   assign inc    = (op_s == OP_INC) && gate_en;
   assign wev    = inc && at_lim;

   // Next-state selection for the count and the wrap pulse.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch can be inferred.
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      case (op_s)
         OP_CLR:  cnt_d = '0;
         OP_LD:   cnt_d = ld_val;
         OP_INC: begin
            // With the gate closed this falls through as a hold.
            if (inc) begin
               if (at_lim) begin
                  cnt_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  // Cannot overflow: cnt_q < lim <= all-ones.
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;
   assign tc   = (cnt_q == lim);

endmodule : hashgen_ctr_ch

// File: rtl/hashgen_ctr_dp.sv
// Top of the chained counter datapath: NCH independent channels whose
// increments can be gated by the previous channel's wrap event, so a
// chain of channels behaves like a mixed-radix counter. Wrap events ripple
// combinationally through the whole chain within one cycle.
module hashgen_ctr_dp
   import hashgen_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2*NCH-1:0]     op,
   input  logic [NCH*WIDTH-1:0] ld_val,
   input  logic [NCH*WIDTH-1:0] lim,
   input  logic [NCH-1:0]       chain,
   output logic [NCH*WIDTH-1:0] cnt,
   output logic [NCH-1:0]       tc,
   output logic [NCH-1:0]       wrap,
   output logic                 all_done
);

   // chain[0] has no upstream channel and the last wrap event has no
   // downstream consumer.
   logic [1:0] unused_bits;

   genvar i;
   generate
      for (i = 0; i < NCH; i++) begin : g_ch
         // Per-channel scalars keep the ripple path acyclic bit by bit.
         logic gate_en;
         logic wev;

         if (i == 0) begin : g_head
            assign gate_en = 1'b1;
         end else begin : g_link
            assign gate_en = ~chain[i] | g_ch[i-1].wev;
         end

         hashgen_ctr_ch #(
            .WIDTH (WIDTH)
         ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .op      (op[2*i +: 2]),
            .gate_en (gate_en),
            .ld_val  (ld_val[WIDTH*i +: WIDTH]),
            .lim     (lim[WIDTH*i +: WIDTH]),
            .cnt     (cnt[WIDTH*i +: WIDTH]),
            .tc      (tc[i]),
            .wrap    (wrap[i]),
            .wev     (wev)
         );
      end
   endgenerate

   assign all_done    = &tc;
   assign unused_bits = {chain[0], g_ch[NCH-1].wev};

endmodule : hashgen_ctr_dp

// File: tb/tb_hashgen_ctr_dp.sv
// Directed bench for hashgen_ctr_dp. The main instance (3 channels, 5 bits)
// is checked against a behavioural model through a scoreboard queue; three
// further instances cover the parameter extremes.
`timescale 1ns/1ps
module tb_hashgen_ctr_dp;
   import hashgen_pkg::*;

   localparam int N = 3;
   localparam int W = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Main instance.
   logic [2*N-1:0] op;
   logic [N*W-1:0] ld_val, lim, cnt;
   logic [N-1:0]   chain, tc, wrap;
   logic           all_done;

   hashgen_ctr_dp #(.NCH(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .ld_val(ld_val), .lim(lim),
      .chain(chain), .cnt(cnt), .tc(tc), .wrap(wrap), .all_done(all_done)
   );

   // Sweep instances: NCH=8/WIDTH=2, NCH=4/WIDTH=2 fully chained, NCH=1/WIDTH=16.
   logic [15:0] op8 = '0, ld8 = '0, lim8 = '1, cnt8;
   logic [7:0]  chain8 = '0, tc8, wrap8;
   logic        done8;
   hashgen_ctr_dp #(.NCH(8), .WIDTH(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .op(op8), .ld_val(ld8), .lim(lim8),
      .chain(chain8), .cnt(cnt8), .tc(tc8), .wrap(wrap8), .all_done(done8)
   );

   logic [7:0] op4 = '0, ld4 = '0, lim4 = '1, cnt4;
   logic [3:0] chain4 = '1, tc4, wrap4;
   logic       done4;
   hashgen_ctr_dp #(.NCH(4), .WIDTH(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .op(op4), .ld_val(ld4), .lim(lim4),
      .chain(chain4), .cnt(cnt4), .tc(tc4), .wrap(wrap4), .all_done(done4)
   );

   logic [1:0]  op1 = '0;
   logic [15:0] ld1 = '0, lim1 = '1, cnt1;
   logic [0:0]  chain1 = '0, tc1, wrap1;
   logic        done1;
   hashgen_ctr_dp #(.NCH(1), .WIDTH(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .op(op1), .ld_val(ld1), .lim(lim1),
      .chain(chain1), .cnt(cnt1), .tc(tc1), .wrap(wrap1), .all_done(done1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: expected post-edge state is pushed when stimulus is applied.
   typedef struct {
      logic [N*W-1:0] cnt;
      logic [N-1:0]   wrap;
      string          tag;
   } exp_t;

   exp_t           sbq[$];
   logic [W-1:0]   m_cnt [N];

   task automatic set_op(input int ch, input op_e o);
      op[2*ch +: 2] = o;
   endtask

   task automatic set_lim(input int ch, input int v);
      lim[W*ch +: W] = W'(v);
   endtask

   task automatic set_ld(input int ch, input int v);
      ld_val[W*ch +: W] = W'(v);
   endtask

   // Predict the next state from the model, clock once, compare.
   task automatic cycle(input string tag);
      exp_t         e;
      exp_t         got;
      logic         up_wev;
      logic         g;
      logic [1:0]   o;
      logic [W-1:0] c, l, nxt;
      logic [N-1:0] e_tc;
      up_wev = 1'b0;
      for (int i = 0; i < N; i++) begin
         o   = op[2*i +: 2];
         c   = m_cnt[i];
         l   = lim[W*i +: W];
         g   = (i == 0) || !chain[i] || up_wev;
         nxt = c;
         e.wrap[i] = 1'b0;
         if (o == 2'b10) nxt = '0;
         else if (o == 2'b11) nxt = ld_val[W*i +: W];
         else if (o == 2'b01 && g) begin
            if (c >= l) begin
               nxt = '0;
               e.wrap[i] = 1'b1;
            end else begin
               nxt = c + 1'b1;
            end
         end
         e.cnt[W*i +: W] = nxt;
         up_wev = (o == 2'b01) && g && (c >= l);
      end
      e.tag = tag;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      check({got.tag, "/cnt"}, 64'(cnt), 64'(got.cnt));
      check({got.tag, "/wrap"}, 64'(wrap), 64'(got.wrap));
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = got.cnt[W*i +: W];
         e_tc[i]  = (m_cnt[i] == lim[W*i +: W]);
      end
      check({got.tag, "/tc"}, 64'(tc), 64'(e_tc));
      check({got.tag, "/all_done"}, 64'(all_done), 64'(&e_tc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int seq032 [6] = '{1, 2, 3, 4, 0, 1};
      logic [3:0] ew;

      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      op     = '0;
      ld_val = '0;
      chain  = '0;
      lim    = '0;
      set_lim(0, 0); set_lim(1, 9); set_lim(2, 3);

      // Reset state, tc follows lim during reset.
      #1;
      check("rst/cnt", 64'(cnt), 64'(0));
      check("rst/wrap", 64'(wrap), 64'(0));
      check("rst/tc", 64'(tc), 64'(3'b001));
      check("rst/all_done", 64'(all_done), 64'(0));
      lim = '0;
      #1;
      check("rst/all_done_lim0", 64'(all_done), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single channel count to limit 4.
      set_lim(0, 4); set_lim(1, 9); set_lim(2, 3);
      set_op(0, OP_INC);
      for (int k = 0; k < 6; k++) begin
         cycle($sformatf("inc_lim4_%0d", k));
         check($sformatf("seq_lim4_%0d", k), 64'(cnt[W-1:0]), 64'(seq032[k]));
      end

      // Count to 7 then assert reset between edges.
      set_op(0, OP_CLR);
      cycle("clr0");
      set_lim(0, 10);
      set_op(0, OP_INC);
      for (int k = 0; k < 7; k++) cycle($sformatf("to7_%0d", k));
      check("pre_rst/cnt0", 64'(cnt[W-1:0]), 64'(7));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst/cnt", 64'(cnt), 64'(0));
      check("async_rst/wrap", 64'(wrap), 64'(0));
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_rst_inc");

      // Load above the limit then increment.
      set_op(0, OP_LD); set_ld(0, 25);
      cycle("ld25");
      set_op(0, OP_INC);
      cycle("ld25_inc_wraps");
      check("ld25/wrap0", 64'(wrap[0]), 64'(1));

      // Two-channel chain, limits (3,2).
      op = '0;
      set_op(0, OP_CLR); set_op(1, OP_CLR); set_op(2, OP_CLR);
      cycle("clr_all");
      set_lim(0, 3); set_lim(1, 2); set_lim(2, 0);
      chain = 3'b010;
      set_op(0, OP_INC); set_op(1, OP_INC); set_op(2, OP_HOLD);
      for (int k = 0; k < 12; k++) begin
         cycle($sformatf("chain_%0d", k));
         if (k == 10) check("chain/all_done_at_3_2", 64'(all_done), 64'(1));
      end

      // Zero limit: stays at 0 and wraps every cycle.
      chain = '0;
      set_lim(0, 0);
      set_op(1, OP_HOLD);
      for (int k = 0; k < 3; k++) cycle($sformatf("lim0_%0d", k));

      // Mixed commands in one cycle.
      set_lim(0, 20); set_lim(1, 20); set_lim(2, 6);
      set_op(0, OP_LD); set_op(1, OP_LD); set_op(2, OP_LD);
      set_ld(0, 9); set_ld(1, 2); set_ld(2, 6);
      cycle("mix_preload");
      set_op(0, OP_CLR); set_op(1, OP_LD); set_op(2, OP_INC);
      set_ld(1, 5);
      cycle("mix");
      check("mix/cnt", 64'(cnt), 64'({5'd0, 5'd5, 5'd0}));
      check("mix/wrap", 64'(wrap), 64'(3'b100));

      // Ripple through three channels in one cycle, then a closed gate.
      set_lim(0, 0); set_lim(1, 5); set_lim(2, 6);
      chain = 3'b110;
      set_op(0, OP_INC); set_op(1, OP_INC); set_op(2, OP_INC);
      cycle("ripple3");
      cycle("ripple_gate_closed");

      // Parameter sweep with all-ones limits.
      @(negedge clk);
      op8 = 16'h5555;
      op4 = 8'h55;
      op1 = 2'b11;
      ld1 = 16'hFFFD;
      for (int k = 1; k <= 257; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) ew[i] = ((k % (1 << (2 * (i + 1)))) == 0);
         check($sformatf("n4_%0d", k), 64'({wrap4, cnt4}), 64'({ew, 8'(k)}));
         if (k == 255) check("n4/all_done", 64'(done4), 64'(1));
         if (k <= 5) begin
            check($sformatf("n8_cnt_%0d", k), 64'(cnt8), 64'({8{2'(k)}}));
            check($sformatf("n8_wrap_%0d", k), 64'(wrap8), 64'((k % 4 == 0) ? 8'hFF : 8'h00));
            check($sformatf("noX_%0d", k), 64'($isunknown({cnt8, tc8, wrap8, done8, cnt4, tc4,
                  wrap4, done4, cnt1, tc1, wrap1, done1})), 64'(0));
         end
         case (k)
            1: begin
               check("w16_ld", 64'(cnt1), 64'(16'hFFFD));
               op1 = 2'b01;
            end
            2: check("w16_inc", 64'(cnt1), 64'(16'hFFFE));
            3: check("w16_max", 64'({done1, tc1, wrap1, cnt1}), 64'({3'b110, 16'hFFFF}));
            4: check("w16_wrap", 64'({wrap1, cnt1}), 64'({1'b1, 16'h0000}));
            default: ;
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_hashgen_ctr_dp
